// File: rtl/alarm_ctrl_if.sv
// Keypad/button inputs and display/load strobes of the alarm clock sequencer.
// The keypad side holds levels (key, buttons, one_second pulse) and the controller
// answers with Moore strobes decoded from its state register, so there is no ready path.
interface alarm_ctrl_if;
  logic       one_second;
  logic [3:0] key;
  logic       alarm_button;
  logic       time_button;
  logic       shift;
  logic       show_new_time;
  logic       show_alarm;
  logic       load_new_c;
  logic       load_new_a;

  modport master (
    output one_second, key, alarm_button, time_button,
    input  shift, show_new_time, show_alarm, load_new_c, load_new_a
  );

  modport slave (
    input  one_second, key, alarm_button, time_button,
    output shift, show_new_time, show_alarm, load_new_c, load_new_a
  );
endinterface

// File: rtl/alarm_ctrl_fsm.sv
// Alarm clock keypad sequencer: turns key/button activity into shift, load and
// display strobes, and drops a partial entry after TIMEOUT_S seconds of inactivity.
module alarm_ctrl_fsm #(
  parameter int         TIMEOUT_S = 10,
  parameter logic [3:0] NOKEY     = 4'd10
) (
  input  logic        clk,
  input  logic        reset,
  alarm_ctrl_if.slave bus,
  output logic [2:0]  state_dbg
);

  localparam int             CW   = $clog2(TIMEOUT_S + 1);
  localparam logic [CW-1:0]  TMAX = CW'(TIMEOUT_S);

  typedef enum logic [2:0] {
    SHOW_TIME        = 3'd0,
    KEY_STORED       = 3'd1,
    KEY_WAITED       = 3'd2,
    KEY_ENTRY        = 3'd3,
    SHOW_ALARM       = 3'd4,
    SET_ALARM_TIME   = 3'd5,
    SET_CURRENT_TIME = 3'd6
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   count_q, count_d;
  logic            key_pressed;
  logic            timeout;

  // Codes 11..15 behave exactly like NOKEY.
  assign key_pressed = (bus.key != NOKEY) && (bus.key <= 4'd9);
  assign timeout     = (count_q == TMAX);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= SHOW_TIME;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      SHOW_TIME: begin
        if (bus.alarm_button)  state_d = SHOW_ALARM;
        else if (key_pressed)  state_d = KEY_STORED;
      end
      KEY_STORED: state_d = KEY_WAITED;
      KEY_WAITED: begin
        if (timeout)           state_d = SHOW_TIME;
        else if (!key_pressed) state_d = KEY_ENTRY;
      end
      KEY_ENTRY: begin
        if (bus.alarm_button)     state_d = SET_ALARM_TIME;
        else if (bus.time_button) state_d = SET_CURRENT_TIME;
        else if (timeout)         state_d = SHOW_TIME;
        else if (key_pressed)     state_d = KEY_STORED;
      end
      SHOW_ALARM: begin
        if (!bus.alarm_button) state_d = SHOW_TIME;
      end
      SET_ALARM_TIME:   state_d = SHOW_TIME;
      SET_CURRENT_TIME: state_d = SHOW_TIME;
      default:          state_d = SHOW_TIME;
    endcase
  end

  // Only the two waiting states accumulate seconds; every stored key restarts from zero.
  always_comb begin
    count_d = '0;
    if (state_q == KEY_WAITED || state_q == KEY_ENTRY) begin
      count_d = count_q;
      if (bus.one_second && (count_q != TMAX)) count_d = count_q + CW'(1);
    end
  end

  assign bus.shift         = (state_q == KEY_STORED);
  assign bus.show_new_time = (state_q == KEY_STORED) || (state_q == KEY_WAITED) ||
                             (state_q == KEY_ENTRY);
  assign bus.show_alarm    = (state_q == SHOW_ALARM);
  assign bus.load_new_a    = (state_q == SET_ALARM_TIME);
  assign bus.load_new_c    = (state_q == SET_CURRENT_TIME);
  assign state_dbg         = state_q;

endmodule

// File: tb/tb_alarm_ctrl_fsm.sv
// Directed table-driven bench for alarm_ctrl_fsm plus hand-written reset sequence.
module tb_alarm_ctrl_fsm;

  // expected output vector order: {shift, show_new_time, show_alarm, load_new_c, load_new_a}
  localparam logic [4:0] O_IDLE  = 5'b00000;
  localparam logic [4:0] O_SHIFT = 5'b11000;
  localparam logic [4:0] O_SNT   = 5'b01000;
  localparam logic [4:0] O_SA    = 5'b00100;
  localparam logic [4:0] O_LC    = 5'b00010;
  localparam logic [4:0] O_LA    = 5'b00001;
  localparam logic [3:0] NK      = 4'd10;

  typedef struct {
    logic       os;
    logic [3:0] key;
    logic       ab;
    logic       tb;
    logic [4:0] exp;
  } vec_t;

  logic       clk;
  logic       reset;
  logic [2:0] state_dbg;
  int         n_vec;
  int         n_fail;
  vec_t       vecs[$];

  alarm_ctrl_if bus ();

  alarm_ctrl_fsm #(.TIMEOUT_S(10), .NOKEY(4'd10)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [4:0] outs();
    return {bus.shift, bus.show_new_time, bus.show_alarm, bus.load_new_c, bus.load_new_a};
  endfunction

  task automatic check(input string name, input logic [4:0] got, input logic [4:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: outputs %b, expected %b", name, got, exp);
    end
  endtask

  task automatic add(input logic os, input logic [3:0] key, input logic ab, input logic tb,
                     input logic [4:0] exp);
    vec_t v;
    v.os = os; v.key = key; v.ab = ab; v.tb = tb; v.exp = exp;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic os, input logic [3:0] key, input logic ab, input logic tb);
    bus.one_second   = os;
    bus.key          = key;
    bus.alarm_button = ab;
    bus.time_button  = tb;
  endtask

  // Apply one vector, clock it, then sample 1ns after the edge.
  task automatic step(input string name, input vec_t v);
    drive(v.os, v.key, v.ab, v.tb);
    @(posedge clk);
    #1;
    check(name, outs(), v.exp);
  endtask

  task automatic build_table();
    // time set: keys 1..4, each held 3 cycles, 2 idle cycles between, then time_button 5 cycles
    for (int k = 1; k <= 4; k++) begin
      add(0, 4'(k), 0, 0, O_SHIFT);
      add(0, 4'(k), 0, 0, O_SNT);
      add(0, 4'(k), 0, 0, O_SNT);
      add(0, NK,    0, 0, O_SNT);
      add(0, NK,    0, 0, O_SNT);
    end
    add(0, NK, 0, 1, O_LC);
    for (int i = 0; i < 4; i++) add(0, NK, 0, 1, O_IDLE);
    add(0, NK, 0, 0, O_IDLE);

    // alarm set: key 7, then alarm_button
    add(0, 4'd7, 0, 0, O_SHIFT);
    add(0, NK,   0, 0, O_SNT);
    add(0, NK,   0, 0, O_SNT);
    add(0, NK,   1, 0, O_LA);
    add(0, NK,   0, 0, O_IDLE);

    // both buttons in KEY_ENTRY: alarm load wins
    add(0, 4'd3, 0, 0, O_SHIFT);
    add(0, NK,   0, 0, O_SNT);
    add(0, NK,   0, 0, O_SNT);
    add(0, NK,   1, 1, O_LA);
    add(0, NK,   0, 0, O_IDLE);

    // key 5 with time_button in KEY_ENTRY: button wins, no shift
    add(0, 4'd5, 0, 0, O_SHIFT);
    add(0, NK,   0, 0, O_SNT);
    add(0, NK,   0, 0, O_SNT);
    add(0, 4'd5, 0, 1, O_LC);
    add(0, NK,   0, 0, O_IDLE);

    // button while waiting for key release is ignored; code 12 counts as no key
    add(0, 4'd2,  0, 0, O_SHIFT);
    add(0, 4'd2,  1, 0, O_SNT);
    add(0, 4'd2,  1, 0, O_SNT);
    add(0, 4'd12, 1, 0, O_SNT);
    add(0, NK,    1, 0, O_LA);
    add(0, NK,    0, 0, O_IDLE);

    // show alarm: 20 cycles held, then released; time_button alone in SHOW_TIME ignored
    for (int i = 0; i < 20; i++) add(0, NK, 1, 0, O_SA);
    add(0, NK, 0, 0, O_IDLE);
    add(0, NK, 0, 1, O_IDLE);

    // timeout from KEY_ENTRY after 10 pulses
    add(0, 4'd4, 0, 0, O_SHIFT);
    add(0, NK,   0, 0, O_SNT);
    add(0, NK,   0, 0, O_SNT);
    for (int i = 0; i < 9; i++) begin
      add(1, NK, 0, 0, O_SNT);
      add(0, NK, 0, 0, O_SNT);
    end
    add(1, NK, 0, 0, O_SNT);
    add(0, NK, 0, 0, O_IDLE);

    // restart: 9 pulses, key (with coincident pulse) restarts, 10 more needed
    add(0, 4'd1, 0, 0, O_SHIFT);
    add(0, NK,   0, 0, O_SNT);
    add(0, NK,   0, 0, O_SNT);
    for (int i = 0; i < 9; i++) begin
      add(1, NK, 0, 0, O_SNT);
      add(0, NK, 0, 0, O_SNT);
    end
    add(1, 4'd6, 0, 0, O_SHIFT);
    add(0, NK,   0, 0, O_SNT);
    add(0, NK,   0, 0, O_SNT);
    for (int i = 0; i < 9; i++) begin
      add(1, NK, 0, 0, O_SNT);
      add(0, NK, 0, 0, O_SNT);
    end
    add(1, NK, 0, 0, O_SNT);
    add(0, NK, 0, 0, O_IDLE);

    // timeout and release in the same cycle in KEY_WAITED: timeout wins
    add(0, 4'd8, 0, 0, O_SHIFT);
    add(0, 4'd8, 0, 0, O_SNT);
    for (int i = 0; i < 9; i++) begin
      add(1, 4'd8, 0, 0, O_SNT);
      add(0, 4'd8, 0, 0, O_SNT);
    end
    add(1, 4'd8, 0, 0, O_SNT);
    add(0, NK,   0, 0, O_IDLE);
    add(0, NK,   0, 1, O_IDLE);
  endtask

  initial begin
    vec_t v;
    n_vec  = 0;
    n_fail = 0;
    reset  = 1'b0;
    drive(0, NK, 0, 0);
    #1 reset = 1'b1;
    #2;
    check("reset_async", outs(), O_IDLE);
    @(posedge clk);
    #1;
    check("reset_held", outs(), O_IDLE);
    #2 reset = 1'b0;
    @(posedge clk);
    #1;
    check("after_reset", outs(), O_IDLE);

    build_table();
    foreach (vecs[i]) step($sformatf("vec%0d", i), vecs[i]);

    // reset asserted mid-KEY_WAITED abandons the entry without a clock edge
    v.os = 0; v.key = 4'd9; v.ab = 0; v.tb = 0;
    v.exp = O_SHIFT; step("rst_seq_shift", v);
    v.exp = O_SNT;   step("rst_seq_wait", v);
    #2 reset = 1'b1;
    #1;
    check("rst_mid_wait", outs(), O_IDLE);
    drive(0, NK, 0, 0);
    @(posedge clk);
    #1;
    check("rst_mid_held", outs(), O_IDLE);
    #2 reset = 1'b0;
    // in SHOW_TIME a time_button is ignored; a surviving entry would load instead
    v.os = 0; v.key = NK; v.ab = 0; v.tb = 1; v.exp = O_IDLE;
    step("rst_release_1", v);
    step("rst_release_2", v);
    v.tb = 0; v.key = 4'd0; v.exp = O_SHIFT;
    step("rst_then_key0", v);
    v.key = NK; v.exp = O_SNT;
    step("rst_then_wait", v);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/alarm_ctrl_fsm.md
# alarm_ctrl_fsm

Keypad/button sequencing controller for the alarm clock. It decodes keypad and button activity into the one-cycle strobes that drive the rest of the design:

- `shift` to the key-entry register.
- `load_new_c` to the time counter.
- `load_new_a` to the alarm register.
- `show_new_time` and `show_alarm` to the display mux.

It also abandons a partial key entry after a programmable number of seconds of inactivity.

## Interface
- `TIMEOUT_S`, default 10: inactivity timeout, in `one_second` pulses.
- `NOKEY`, default 4'd10: key code meaning "no key pressed". Codes 0–9 are digits. Codes 11–15 are treated as `NOKEY`.
- `clk`  input  1  system clock.
- `reset`  input  1  asynchronous, active-high reset.
- `one_second`  input  1  single-cycle pulse, once per second, synchronous to `clk`.
- `key`  input  4  debounced keypad code, held for the duration of the press.
- `alarm_button`  input  1  level: alarm button held.
- `time_button`  input  1  level: time button held.
- `shift`  output  1  one-cycle strobe: shift `key` into the entry register.
- `show_new_time`  output  1  display shows the entry register instead of current time.
- `show_alarm`  output  1  display shows the stored alarm time.
- `load_new_c`  output  1  one-cycle strobe: load the entry register into the time counter.
- `load_new_a`  output  1  one-cycle strobe: load the entry register into the alarm register.

## Operation
A key is "pressed" when `key` is 0–9; otherwise it is "none".

States and next-state rules (first matching rule wins):
- **SHOW_TIME** (reset state):
  - `alarm_button` → SHOW_ALARM.
  - Else key pressed → KEY_STORED.
  - Else stay.
- **KEY_STORED**: unconditionally → KEY_WAITED after one cycle.
- **KEY_WAITED** (waits for key release):
  - Timeout reached → SHOW_TIME.
  - Else key none → KEY_ENTRY.
  - Else stay.
- **KEY_ENTRY**:
  - `alarm_button` → SET_ALARM_TIME.
  - Else `time_button` → SET_CURRENT_TIME.
  - Else timeout reached → SHOW_TIME.
  - Else key pressed → KEY_STORED.
  - Else stay.
- **SHOW_ALARM**: `alarm_button` low → SHOW_TIME; else stay.
- **SET_ALARM_TIME**: unconditionally → SHOW_TIME after one cycle.
- **SET_CURRENT_TIME**: unconditionally → SHOW_TIME after one cycle.

Outputs are a Moore decode of the state register (no input-to-output combinational path):
- `shift` = 1 only in KEY_STORED.
- `show_new_time` = 1 in KEY_STORED, KEY_WAITED and KEY_ENTRY.
- `show_alarm` = 1 only in SHOW_ALARM.
- `load_new_a` = 1 only in SET_ALARM_TIME.
- `load_new_c` = 1 only in SET_CURRENT_TIME.
- At most one of `shift`, `load_new_a`, `load_new_c`, `show_alarm` is high in any cycle.

Timeout counter, width `$clog2(TIMEOUT_S+1)`:
- Cleared to 0 in every cycle the state is SHOW_TIME, KEY_STORED, SHOW_ALARM, SET_ALARM_TIME or SET_CURRENT_TIME.
- In KEY_ENTRY and KEY_WAITED, increments on `one_second`, saturating at `TIMEOUT_S`.
- "Timeout reached" means count == `TIMEOUT_S`. It is evaluated on the registered count.
- Each stored key therefore restarts the timeout.

## Timing
Reset:
- State → SHOW_TIME and count → 0 immediately on `reset` rising, with no clock required.
- All outputs are 0 during and after reset until the first transition.
- Reset asserted mid-entry abandons the entry; no load strobe is issued.

Latency:
- `shift` goes high on the first clock edge after `key` goes to a digit in SHOW_TIME or KEY_ENTRY, and stays high for exactly one cycle.
- A key held for N cycles produces exactly one `shift`.
- `load_new_c` / `load_new_a` go high on the first edge after the button is sampled in KEY_ENTRY, and stay high for one cycle. State is SHOW_TIME on the following edge.
- A button held longer than one cycle does not re-trigger a load. In SHOW_TIME a held `alarm_button` goes to SHOW_ALARM; a held `time_button` is ignored.

Boundaries:
- `alarm_button` and `time_button` both high in KEY_ENTRY: the alarm load wins.
- A button and a key together in KEY_ENTRY: the button wins.
- Button pressed in KEY_WAITED: ignored until the key is released.
- Timeout and key release in the same cycle in KEY_WAITED: timeout wins.
- `one_second` coinciding with a transition into KEY_STORED: the count is cleared, not incremented.

## Test plan
1. **Reset**: reset asserted mid-KEY_WAITED → all outputs 0 with no clock edge; SHOW_TIME after release.
2. **Time set**:
   - Stimulus: keys 1, 2, 3, 4, each held 3 cycles with 2 idle cycles between; then `time_button` held 5 cycles.
   - Required: exactly 4 single-cycle `shift` pulses; `show_new_time` high from the first `shift` until `load_new_c`; exactly one `load_new_c` pulse; next cycle all outputs 0.
3. **Alarm set**: key 7 then `alarm_button` → one `shift`, then one `load_new_a`; `load_new_c` never asserted.
4. **Timeout**:
   - Stimulus: `TIMEOUT_S`=10; one key, then 10 `one_second` pulses with no input.
   - Required: return to SHOW_TIME on the edge after the 10th pulse; `show_new_time` falls; no load strobe.
   - Variant: a key pressed after 9 pulses restarts the count, and 10 further pulses are required.
5. **Show alarm**: `alarm_button` held 20 cycles in SHOW_TIME → `show_alarm` high for 20 cycles starting one cycle after press; no `load_new_a`.
6. **Priority**: both buttons in KEY_ENTRY → `load_new_a` only. Key 5 and `time_button` together in KEY_ENTRY → `load_new_c`, no `shift`.
